// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between port 0 (core) and port 1 (loader/debug).
// Define RAM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 has fixed priority.
module ram_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,

    output logic [DATA_W-1:0] rdata,

    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              xfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    // Read return pipeline: stage 1 tracks the command cycle, stage 2 the RAM output cycle.
    logic              rd_v1_q,  rd_v1_d;
    logic              rd_id1_q, rd_id1_d;
    logic              rd_v2_q,  rd_v2_d;
    logic              rd_id2_q, rd_id2_d;

`ifdef RAM_ARB_RR_EN
    // ptr_q names the port that wins the next conflict.
    logic ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (gnt0) begin
            ptr_d = 1'b1;
        end else if (gnt1) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
`ifdef RAM_ARB_RR_EN
            if (req0 && req1) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
`else
            gnt0 = req0;
            gnt1 = req1 & ~req0;
`endif
        end
    end

    always_comb begin
        xfer      = gnt0 | gnt1;
        sel_we    = gnt1 ? we1    : we0;
        sel_addr  = gnt1 ? addr1  : addr0;
        sel_wdata = gnt1 ? wdata1 : wdata0;
    end

    // Address and data hold through idle cycles; only the write strobe returns to 0.
    always_comb begin
        ram_we_d    = xfer & sel_we;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (xfer) begin
            ram_addr_d  = sel_addr;
            ram_wdata_d = sel_wdata;
        end
    end

    always_comb begin
        rd_v1_d  = xfer & ~sel_we;
        rd_id1_d = gnt1;
        rd_v2_d  = rd_v1_q;
        rd_id2_d = rd_id1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rd_v1_q     <= 1'b0;
            rd_id1_q    <= 1'b0;
            rd_v2_q     <= 1'b0;
            rd_id2_q    <= 1'b0;
        end else begin
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            rd_v1_q     <= rd_v1_d;
            rd_id1_q    <= rd_id1_d;
            rd_v2_q     <= rd_v2_d;
            rd_id2_q    <= rd_id2_d;
        end
    end

    always_comb begin
        ram_we    = ram_we_q;
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        rvalid0   = rd_v2_q & ~rd_id2_q;
        rvalid1   = rd_v2_q & rd_id2_q;
        rdata     = ram_rdata;
    end

    a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    a_gnt0_req   : assert property (@(posedge clk) disable iff (rst) gnt0 |-> req0);
    a_gnt1_req   : assert property (@(posedge clk) disable iff (rst) gnt1 |-> req1);

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: a request-level model predicts grants, RAM writes and read returns.
// Builds with or without RAM_ARB_RR_EN; the model follows the same macro.
module tb_ram_arbiter;
    localparam int AW = 6;
    localparam int DW = 32;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, gnt0, rvalid0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1, we1, gnt1, rvalid1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM
    logic [DW-1:0] ram_mem [2**AW];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model
    typedef struct { int cyc; logic [AW-1:0] a; logic [DW-1:0] d; } exp_t;
    typedef struct { bit we; logic [AW-1:0] a; logic [DW-1:0] d; } op_t;

    logic [DW-1:0] mdl_mem [2**AW];
    bit            mdl_ptr = 1'b0;
    exp_t          wq[$], rq0[$], rq1[$];
    op_t           pq0[$], pq1[$];
    int            glog[$];

    task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                        output int g);
        exp_t          e;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            if (r0 && r1) g = RR ? int'(mdl_ptr) : 0;
            else if (r0)  g = 0;
            else if (r1)  g = 1;
        end
        chk("gnt0", DW'(gnt0), DW'(g == 0));
        chk("gnt1", DW'(gnt1), DW'(g == 1));
        if (gnt0) glog.push_back(0);
        else if (gnt1) glog.push_back(1);
        if (g >= 0) begin
            mdl_ptr = (g == 0);
            w = (g == 1) ? w1 : w0;
            a = (g == 1) ? a1 : a0;
            d = (g == 1) ? d1 : d0;
            e.a = a;
            if (w) begin
                mdl_mem[a] = d;
                e.cyc = cyc + 1;
                e.d   = d;
                wq.push_back(e);
            end else begin
                e.cyc = cyc + 2;
                e.d   = mdl_mem[a];
                if (g == 1) rq1.push_back(e);
                else        rq0.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, 0, '0, '0, g);
    endtask

    // Presents the head of each port queue, holding it until granted; optional random request gaps.
    task automatic run_ports(input int idle_pct);
        int  g;
        int  n;
        bit  r0, r1;
        op_t o0, o1;
        n = 0;
        while ((pq0.size() > 0 || pq1.size() > 0) && n < 2000) begin
            o0 = '{0, '0, '0};
            o1 = '{0, '0, '0};
            r0 = 0;
            r1 = 0;
            if (pq0.size() > 0) begin o0 = pq0[0]; r0 = ($urandom_range(99) >= idle_pct); end
            if (pq1.size() > 0) begin o1 = pq1[0]; r1 = ($urandom_range(99) >= idle_pct); end
            step(r0, o0.we, o0.a, o0.d, r1, o1.we, o1.a, o1.d, g);
            if (g == 0) void'(pq0.pop_front());
            else if (g == 1) void'(pq1.pop_front());
            n++;
        end
        chk("run_ports_drained", DW'(pq0.size() + pq1.size()), '0);
        pq0.delete();
        pq1.delete();
    endtask

    task automatic model_reset();
        mdl_ptr = 1'b0;
        wq.delete();
        rq0.delete();
        rq1.delete();
    endtask

    // Monitor: pops an expectation whenever the DUT presents (or should present) an output
    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            chk("ram_we", DW'(ram_we), DW'(1'b1));
            chk("ram_addr", DW'(ram_addr), DW'(wq[0].a));
            chk("ram_wdata", ram_wdata, wq[0].d);
            void'(wq.pop_front());
        end else if (ram_we) begin
            chk("ram_we_spurious", DW'(ram_we), '0);
        end
        if (rq0.size() > 0 && rq0[0].cyc == cyc) begin
            chk("rvalid0", DW'(rvalid0), DW'(1'b1));
            chk("rdata0", rdata, rq0[0].d);
            void'(rq0.pop_front());
        end else if (rvalid0) begin
            chk("rvalid0_spurious", DW'(rvalid0), '0);
        end
        if (rq1.size() > 0 && rq1[0].cyc == cyc) begin
            chk("rvalid1", DW'(rvalid1), DW'(1'b1));
            chk("rdata1", rdata, rq1[0].d);
            void'(rq1.pop_front());
        end else if (rvalid1) begin
            chk("rvalid1_spurious", DW'(rvalid1), '0);
        end
    end

    initial begin
        int            g;
        int            exp_ord[4];
        logic [DW-1:0] saved;
        rst = 1'b0;
        req0 = 1; we0 = 1; addr0 = 1; wdata0 = 32'd15;
        req1 = 1; we1 = 1; addr1 = 9; wdata1 = 32'd99;
        #2 rst = 1'b1;

        // Reset with both ports requesting
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt0", DW'(gnt0), '0);
        chk("rst_gnt1", DW'(gnt1), '0);
        chk("rst_ram_we", DW'(ram_we), '0);
        chk("rst_ram_addr", DW'(ram_addr), '0);
        chk("rst_ram_wdata", ram_wdata, '0);
        chk("rst_rvalid0", DW'(rvalid0), '0);
        chk("rst_rvalid1", DW'(rvalid1), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        // Preload every address from port 0 while port 1 also requests in the first cycle
        glog.delete();
        for (int i = 0; i < 2**AW; i++) pq0.push_back('{1'b1, AW'(i), DW'($urandom)});
        pq1.push_back('{1'b1, AW'(9), 32'd99});
        run_ports(0);
        chk("first_gnt_after_reset", DW'(glog[0]), '0);

        // Port 0 write then read @1
        pq0.push_back('{1'b1, AW'(1), 32'd15});
        pq0.push_back('{1'b0, AW'(1), '0});
        run_ports(0);
        idle(3);
        step(0, 0, '0, '0, 1, 0, AW'(9), '0, g);

        // Four conflicting writes
        glog.delete();
        pq0.push_back('{1'b1, AW'(2), 32'd25});
        pq0.push_back('{1'b1, AW'(3), 32'd26});
        pq1.push_back('{1'b1, AW'(4), 32'd35});
        pq1.push_back('{1'b1, AW'(5), 32'd36});
        run_ports(0);
        if (RR) exp_ord = '{0, 1, 0, 1};
        else    exp_ord = '{0, 0, 1, 1};
        chk("conflict_grant_count", DW'(glog.size()), DW'(4));
        for (int i = 0; i < 4; i++) chk($sformatf("conflict_order[%0d]", i), DW'(glog[i]), DW'(exp_ord[i]));
        for (int i = 2; i <= 5; i++) pq0.push_back('{1'b0, AW'(i), '0});
        run_ports(0);

        // Back-to-back reads on port 1
        pq1.push_back('{1'b0, AW'(4), '0});
        pq1.push_back('{1'b0, AW'(2), '0});
        pq1.push_back('{1'b0, AW'(1), '0});
        run_ports(0);
        idle(3);

        // Withdrawal: req1 rises while port 0 is granted, then drops
        step(1, 0, AW'(2), '0, 1, 1, AW'(7), 32'd77, g);
        idle(1);
        step(1, 0, AW'(3), '0, 1, 0, AW'(3), '0, g);
        step(0, 0, '0, '0, 1, 0, AW'(7), '0, g);
        idle(3);

        // Reset one cycle after a read grant: return is dropped
        step(0, 0, '0, '0, 1, 0, AW'(5), '0, g);
        rst = 1'b1;
        model_reset();
        idle(2);
        rst = 1'b0;
        idle(3);

        // Reset one cycle after a write grant: write is not performed
        saved = mdl_mem[6];
        step(1, 1, AW'(6), 32'hDEAD_BEEF, 0, 0, '0, '0, g);
        rst = 1'b1;
        model_reset();
        mdl_mem[6] = saved;
        idle(2);
        rst = 1'b0;
        step(1, 0, AW'(6), '0, 0, 0, '0, '0, g);
        idle(3);

        // Randomized traffic with request gaps
        for (int i = 0; i < 60; i++) begin
            pq0.push_back('{1'($urandom), AW'($urandom_range(2**AW - 1)), DW'($urandom)});
            pq1.push_back('{1'($urandom), AW'($urandom_range(2**AW - 1)), DW'($urandom)});
        end
        run_ports(25);

        // Fully random per-cycle requests
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(99) < 70), 1'($urandom), AW'($urandom_range(2**AW - 1)), DW'($urandom),
                 1'($urandom_range(99) < 70), 1'($urandom), AW'($urandom_range(2**AW - 1)), DW'($urandom), g);
        end
        idle(4);
        chk("scoreboard_empty", DW'(wq.size() + rq0.size() + rq1.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
